// File: rtl/cpu_mem_resp_pkg.sv
// Shared types and constants for the CPU memory responder.
package cpu_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IM = 2'd1,
    BUSY_DM = 2'd2
  } resp_state_t;

  localparam int unsigned PORT_IM = 0;
  localparam int unsigned PORT_DM = 1;
  localparam int unsigned CNT_W   = 4;

endpackage

// File: rtl/sram_1p_bw.sv
// Byte-writable word array: synchronous masked write, combinational read.
module sram_1p_bw #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [3:0]        i_bweb,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (!i_bweb[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Serves the CPU instruction and data ports from one shared array with a fixed
// access latency, stalling the CPU pipeline while either port is pending.
module cpu_mem_responder
  import cpu_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned ACC_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_CEB,
  input  logic        IM_WEB,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic        DM_CEB,
  input  logic        DM_WEB,
  input  logic [3:0]  DM_BWEB,
  input  logic [31:0] DM_A,
  input  logic [31:0] DM_IN,
  output logic [31:0] DM_OUT,
  output logic [1:0]  busStall
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_LAT - 1);

  resp_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_web, w_web_nxt;
  logic [3:0]        r_bweb, w_bweb_nxt;
  logic [31:0]       r_din, w_din_nxt;
  logic              r_served_im, r_served_dm;
  logic [31:0]       r_instr, r_dm_out;

  logic        w_req_im, w_req_dm;
  logic        w_done_im, w_done_dm;
  logic        w_grant_im, w_grant_dm;
  logic        w_load_im, w_load_dm;
  logic        w_we;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^{IM_WEB, pc[31:ADDR_W+2], pc[1:0], DM_A[31:ADDR_W+2], DM_A[1:0]};

  assign w_req_im  = ~IM_CEB & ~r_served_im;
  assign w_req_dm  = ~DM_CEB & ~r_served_dm;
  assign w_done_im = (r_state == BUSY_IM) && (r_cnt == '0);
  assign w_done_dm = (r_state == BUSY_DM) && (r_cnt == '0);

  assign busStall = rst ? 2'b00 : {w_req_dm & ~w_done_dm, w_req_im & ~w_done_im};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_web_nxt   = r_web;
    w_bweb_nxt  = r_bweb;
    w_din_nxt   = r_din;
    w_grant_im  = 1'b0;
    w_grant_dm  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_dm)      w_grant_dm = 1'b1;
        else if (w_req_im) w_grant_im = 1'b1;
      end
      BUSY_IM: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = IDLE;
          if (w_req_dm) w_grant_dm = 1'b1;
        end
      end
      BUSY_DM: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = IDLE;
          if (w_req_im) w_grant_im = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_grant_dm) begin
      w_state_nxt = BUSY_DM;
      w_cnt_nxt   = CNT_INIT;
      w_addr_nxt  = DM_A[ADDR_W+1:2];
      w_web_nxt   = DM_WEB;
      w_bweb_nxt  = DM_BWEB;
      w_din_nxt   = DM_IN;
    end else if (w_grant_im) begin
      w_state_nxt = BUSY_IM;
      w_cnt_nxt   = CNT_INIT;
      w_addr_nxt  = pc[ADDR_W+1:2];
      w_web_nxt   = 1'b1;
      w_bweb_nxt  = 4'hF;
    end
  end

  // Read data is captured on the edge entering a completion cycle, so the
  // array is read at the address that cycle will hold.
  assign w_load_im = (w_state_nxt == BUSY_IM) && (w_cnt_nxt == '0);
  assign w_load_dm = (w_state_nxt == BUSY_DM) && (w_cnt_nxt == '0) && w_web_nxt;
  assign w_we      = w_done_dm & ~r_web & ~rst;

  sram_1p_bw #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_bweb (r_bweb),
    .i_waddr(r_addr),
    .i_wdata(r_din),
    .i_raddr(w_addr_nxt),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_web       <= 1'b1;
      r_bweb      <= 4'hF;
      r_din       <= '0;
      r_served_im <= 1'b0;
      r_served_dm <= 1'b0;
      r_instr     <= '0;
      r_dm_out    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_web   <= w_web_nxt;
      r_bweb  <= w_bweb_nxt;
      r_din   <= w_din_nxt;
      // The CPU advanced, so any still-low CEB is a fresh request.
      if (busStall == 2'b00) begin
        r_served_im <= 1'b0;
        r_served_dm <= 1'b0;
      end else begin
        if (w_done_im) r_served_im <= 1'b1;
        if (w_done_dm) r_served_dm <= 1'b1;
      end
      if (w_load_im) r_instr  <= w_rdata;
      if (w_load_dm) r_dm_out <= w_rdata;
    end
  end

  assign instr  = r_instr;
  assign DM_OUT = r_dm_out;

endmodule
